fpu_apu_req_arbiter: RTL and testbench



---
 rtl/fpu_apu_req_arbiter.sv | 108 ++++++++++
 tb/tb_fpu_apu_req_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_apu_req_arbiter.sv
// Per-APU round-robin request arbiter with a one-entry registered output slot.
// Collects decoder requests from all masters and forwards one per cycle to the APU.
module fpu_apu_req_arbiter #(
    parameter int NB_CORES      = 4,
    parameter int ID_WIDTH      = 8,
    parameter int PAYLOAD_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NB_CORES-1:0]               data_req_i,
    input  logic [NB_CORES*ID_WIDTH-1:0]      data_ID_i,
    input  logic [NB_CORES*PAYLOAD_WIDTH-1:0] data_payload_i,
    output logic [NB_CORES-1:0]               data_gnt_o,
    output logic                              apu_req_o,
    output logic [ID_WIDTH-1:0]               apu_ID_o,
    output logic [PAYLOAD_WIDTH-1:0]          apu_payload_o,
    input  logic                              apu_gnt_i
);

    localparam int PTR_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    logic                     valid_q;
    logic [ID_WIDTH-1:0]      id_q;
    logic [PAYLOAD_WIDTH-1:0] payload_q;

    logic                     slot_free;
    logic                     any_req;
    logic                     mst_hs;
    logic [PTR_W-1:0]         winner;
    logic [ID_WIDTH-1:0]      win_id;
    logic [PAYLOAD_WIDTH-1:0] win_payload;

    // The slot accepts a new request when empty or being drained this cycle.
    // Holding reset also blocks grants so no master believes it was served.
    assign slot_free = rst_n & (~valid_q | apu_gnt_i);
    assign any_req   = |data_req_i;
    assign mst_hs    = any_req & slot_free;

    generate
        if (NB_CORES == 1) begin : g_single
            assign winner     = '0;
            assign data_gnt_o = data_req_i & slot_free;
        end else begin : g_rr
            logic [PTR_W-1:0] rr_ptr_q;
            logic [PTR_W-1:0] rr_ptr_d;
            logic [PTR_W:0]   scan_idx;
            logic             found;

            // Scan upward from the pointer, wrapping, and keep the first requester.
            always_comb begin
                winner   = '0;
                found    = 1'b0;
                scan_idx = '0;
                for (int i = 0; i < NB_CORES; i++) begin
                    scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
                    if (scan_idx >= (PTR_W+1)'(NB_CORES))
                        scan_idx = scan_idx - (PTR_W+1)'(NB_CORES);
                    if (!found && data_req_i[scan_idx[PTR_W-1:0]]) begin
                        found  = 1'b1;
                        winner = scan_idx[PTR_W-1:0];
                    end
                end
            end

            // Only the winner sees a grant, and only when the slot can take it.
            always_comb begin
                data_gnt_o = '0;
                if (any_req)
                    data_gnt_o[winner] = slot_free;
            end

            // Next pointer sits just past the winner, wrapping at NB_CORES-1.
            assign rr_ptr_d = (winner == PTR_W'(NB_CORES - 1)) ?
                              '0 : winner + PTR_W'(1);

            // Pointer advances only on a master handshake.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rr_ptr_q <= '0;
                else if (mst_hs)
                    rr_ptr_q <= rr_ptr_d;
            end
        end
    endgenerate

    assign win_id      = data_ID_i[int'(winner)*ID_WIDTH +: ID_WIDTH];
    assign win_payload = data_payload_i[int'(winner)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];

    // Output slot: capture on master handshake, clear valid on a pure drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            id_q      <= '0;
            payload_q <= '0;
        end else if (mst_hs) begin
            valid_q   <= 1'b1;
            id_q      <= win_id;
            payload_q <= win_payload;
        end else if (apu_gnt_i) begin
            valid_q   <= 1'b0;
        end
    end

    assign apu_req_o     = valid_q;
    assign apu_ID_o      = id_q;
    assign apu_payload_o = payload_q;

endmodule

// File: tb/tb_fpu_apu_req_arbiter.sv
// Directed bench for fpu_apu_req_arbiter with NB_CORES=4 and NB_CORES=3.
// Expected values are hand-derived from the round-robin rules.
module tb_fpu_apu_req_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // NB_CORES = 4 instance
    logic [3:0]   req4;
    logic [7:0]   id4_a [4];
    logic [31:0]  pl4_a [4];
    logic [31:0]  id4;
    logic [127:0] pl4;
    logic [3:0]   gnt4;
    logic         areq4;
    logic [7:0]   aid4;
    logic [31:0]  apl4;
    logic         agnt4;

    // NB_CORES = 3 instance
    logic [2:0]   req3;
    logic [23:0]  id3;
    logic [95:0]  pl3;
    logic [2:0]   gnt3;
    logic         areq3;
    logic [7:0]   aid3;
    logic [31:0]  apl3;
    logic         agnt3;

    always_comb begin
        id4 = '0;
        pl4 = '0;
        for (int k = 0; k < 4; k++) begin
            id4[k*8 +: 8]   = id4_a[k];
            pl4[k*32 +: 32] = pl4_a[k];
        end
    end

    always_comb begin
        id3 = '0;
        pl3 = '0;
        for (int k = 0; k < 3; k++) begin
            id3[k*8 +: 8]   = 8'h30 + 8'(k);
            pl3[k*32 +: 32] = 32'hC000_0000 + 32'(k);
        end
    end

    fpu_apu_req_arbiter #(
        .NB_CORES(4), .ID_WIDTH(8), .PAYLOAD_WIDTH(32)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req4), .data_ID_i(id4), .data_payload_i(pl4),
        .data_gnt_o(gnt4),
        .apu_req_o(areq4), .apu_ID_o(aid4), .apu_payload_o(apl4),
        .apu_gnt_i(agnt4)
    );

    fpu_apu_req_arbiter #(
        .NB_CORES(3), .ID_WIDTH(8), .PAYLOAD_WIDTH(32)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req3), .data_ID_i(id3), .data_payload_i(pl3),
        .data_gnt_o(gnt3),
        .apu_req_o(areq3), .apu_ID_o(aid3), .apu_payload_o(apl3),
        .apu_gnt_i(agnt3)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive at negedge, settle 1 time unit before checking.
    task automatic drv4(input logic [3:0] r, input logic g);
        @(negedge clk);
        req4  = r;
        agnt4 = g;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req4  = '0;
        agnt4 = 1'b0;
        req3  = '0;
        agnt3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            id4_a[k] = 8'h10 + 8'(k);
            pl4_a[k] = 32'hA000_0000 + 32'(k);
        end
        id4_a[0] = 8'd3;

        // Reset values
        #2;
        chk("rst_req", areq4, 1'b0);
        chk("rst_id", aid4, 8'h00);
        chk("rst_pl", apl4, 32'h0);
        chk("rst_gnt", gnt4, 4'b0000);
        chk("rst_req3", areq3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Capture ID=3 from master 0, then reset while held
        drv4(4'b0001, 1'b0);
        chk("cap_gnt", gnt4, 4'b0001);
        drv4(4'b0001, 1'b0);
        chk("cap_req", areq4, 1'b1);
        chk("cap_id", aid4, 8'd3);
        chk("hold_gnt", gnt4, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", areq4, 1'b0);
        chk("async_gnt", gnt4, 4'b0000);
        drv4(4'b0000, 1'b0);
        rst_n = 1'b1;
        drv4(4'b0000, 1'b0);
        chk("post_rst_req", areq4, 1'b0);
        chk("post_rst_gnt", gnt4, 4'b0000);

        // Round robin 0,1,2,3,0,1,2,3 with APU always ready
        for (int i = 0; i < 8; i++) begin
            drv4(4'b1111, 1'b1);
            chk($sformatf("rr_gnt%0d", i), gnt4, 4'b0001 << (i % 4));
            if (i > 0) begin
                chk($sformatf("rr_req%0d", i), areq4, 1'b1);
                chk($sformatf("rr_id%0d", i), aid4, id4_a[(i-1) % 4]);
            end
        end
        drv4(4'b0000, 1'b1);
        chk("rr_id_last", aid4, id4_a[3]);
        chk("rr_pl_last", apl4, pl4_a[3]);
        drv4(4'b0000, 1'b1);
        chk("drain_req", areq4, 1'b0);
        chk("drain_id_hold", aid4, id4_a[3]);

        // Pointer 0 -> grant master 1 so pointer becomes 2
        drv4(4'b0010, 1'b1);
        chk("sw_pre", gnt4, 4'b0010);
        drv4(4'b0011, 1'b1);
        chk("sw_wrap0", gnt4, 4'b0001);
        chk("sw_id1", aid4, id4_a[1]);
        drv4(4'b0010, 1'b1);
        chk("sw_next1", gnt4, 4'b0010);
        chk("sw_id0", aid4, id4_a[0]);
        drv4(4'b0000, 1'b1);
        chk("sw_id1b", aid4, id4_a[1]);
        drv4(4'b0000, 1'b1);
        chk("sw_empty", areq4, 1'b0);

        // Back-pressure: slot holds ID=5 / DEADBEEF from master 0
        id4_a[0] = 8'd5;
        pl4_a[0] = 32'hDEAD_BEEF;
        id4_a[1] = 8'h21;
        pl4_a[1] = 32'h2121_2121;
        drv4(4'b0001, 1'b0);
        chk("bp_cap_gnt", gnt4, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            drv4(4'b1010, 1'b0);
            chk($sformatf("bp_gnt%0d", i), gnt4, 4'b0000);
            chk($sformatf("bp_req%0d", i), areq4, 1'b1);
            chk($sformatf("bp_id%0d", i), aid4, 8'd5);
            chk($sformatf("bp_pl%0d", i), apl4, 32'hDEAD_BEEF);
        end
        drv4(4'b1010, 1'b1);
        chk("bp_rel_gnt", gnt4, 4'b0010);
        drv4(4'b0000, 1'b1);
        chk("bp_reload_req", areq4, 1'b1);
        chk("bp_reload_id", aid4, 8'h21);
        chk("bp_reload_pl", apl4, 32'h2121_2121);

        // Spurious APU grant with empty slot and no requests
        drv4(4'b0000, 1'b1);
        chk("sp_req", areq4, 1'b0);
        chk("sp_gnt", gnt4, 4'b0000);
        drv4(4'b0000, 1'b1);
        chk("sp_req2", areq4, 1'b0);
        chk("sp_id_hold", aid4, 8'h21);

        // Single request from master 2, one-cycle latency
        drv4(4'b0100, 1'b0);
        chk("one_gnt", gnt4, 4'b0100);
        chk("one_req_before", areq4, 1'b0);
        drv4(4'b0000, 1'b0);
        chk("one_req", areq4, 1'b1);
        chk("one_id", aid4, id4_a[2]);
        chk("one_pl", apl4, pl4_a[2]);

        // NB_CORES = 3: order 0,1,2 three times
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req3  = 3'b111;
            agnt3 = 1'b1;
            #1;
            chk($sformatf("n3_gnt%0d", i), gnt3, 3'b001 << (i % 3));
            if (i > 0)
                chk($sformatf("n3_id%0d", i), aid3, 8'h30 + 8'((i-1) % 3));
        end
        @(negedge clk);
        req3 = 3'b000;
        #1;
        chk("n3_id_last", aid3, 8'h32);
        chk("n3_pl_last", apl3, 32'hC000_0002);
        @(negedge clk);
        req3 = 3'b011;
        #1;
        chk("n3_after_wrap", gnt3, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
